// File: rtl/seven_seg_scan_if.sv
// Bundles the scanner's control inputs and display outputs.
// The core drives the master side and the scanner implements the slave side.
interface seven_seg_scan_if #(
  parameter int DIGITS = 4
);
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  logic              en;
  logic              load;
  logic [4*DIGITS-1:0] value;
  logic [DIGITS-1:0] dp_in;
  logic [DIGITS-1:0] blank;
  logic [6:0]        seg;
  logic              dp;
  logic [DIGITS-1:0] an;
  logic [IW-1:0]     digit_idx;
  logic              frame_start;

  modport master (
    output en, load, value, dp_in, blank,
    input  seg, dp, an, digit_idx, frame_start
  );

  modport slave (
    input  en, load, value, dp_in, blank,
    output seg, dp, an, digit_idx, frame_start
  );
endinterface

// File: rtl/seven_seg_scan.sv
// Time-multiplexed seven-segment scanner with a frame-coherent shadow register.
// Optional leading-zero suppression is enabled by defining SEVEN_SEG_LZ_BLANK_EN.
module seven_seg_scan #(
  parameter int DIGITS         = 4,
  parameter int REFRESH_DIV    = 1000,
  parameter bit SEG_ACTIVE_LOW = 1'b1,
  parameter bit AN_ACTIVE_LOW  = 1'b1
) (
  input logic             clk,
  input logic             rst,
  seven_seg_scan_if.slave bus
);
  localparam int IW  = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int RCW = $clog2(REFRESH_DIV);
  localparam logic [RCW-1:0] RC_LAST  = RCW'(REFRESH_DIV - 1);
  localparam logic [IW-1:0]  IDX_LAST = IW'(DIGITS - 1);

  logic [RCW-1:0]      rc;
  logic [IW-1:0]       idx;
  logic                tick;
  logic                wrap;

  logic [4*DIGITS-1:0] pend_value, sh_value;
  logic [DIGITS-1:0]   pend_dp, sh_dp;
  logic [DIGITS-1:0]   pend_blank, sh_blank;
  logic                pend_flag;

  logic [DIGITS-1:0]   dark;
  logic [3:0]          nib;
  logic [6:0]          seg_a;
  logic                dp_a;
  logic [DIGITS-1:0]   an_a;

  logic [6:0]          seg_q;
  logic                dp_q;
  logic [DIGITS-1:0]   an_q;
  logic [IW-1:0]       idx_q;
  logic                fs_q;

  function automatic logic [6:0] decode(input logic [3:0] n);
    case (n)
      4'h0: decode = 7'b1111110;
      4'h1: decode = 7'b0110000;
      4'h2: decode = 7'b1101101;
      4'h3: decode = 7'b1111001;
      4'h4: decode = 7'b0110011;
      4'h5: decode = 7'b1011011;
      4'h6: decode = 7'b1011111;
      4'h7: decode = 7'b1110000;
      4'h8: decode = 7'b1111111;
      4'h9: decode = 7'b1111011;
      4'hA: decode = 7'b1110111;
      4'hB: decode = 7'b0011111;
      4'hC: decode = 7'b1001110;
      4'hD: decode = 7'b0111101;
      4'hE: decode = 7'b1001111;
      default: decode = 7'b1000111;
    endcase
  endfunction

  assign tick = bus.en && (rc == RC_LAST);
  assign wrap = tick && (idx == IDX_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      rc  <= '0;
      idx <= '0;
    end else if (bus.en) begin
      if (tick) begin
        rc  <= '0;
        idx <= (idx == IDX_LAST) ? '0 : idx + IW'(1);
      end else begin
        rc <= rc + RCW'(1);
      end
    end
  end

  // A load on the wrap edge bypasses pending so that frame shows it immediately.
  always_ff @(posedge clk) begin
    if (rst) begin
      pend_value <= '0;
      pend_dp    <= '0;
      pend_blank <= '0;
      pend_flag  <= 1'b0;
      sh_value   <= '0;
      sh_dp      <= '0;
      sh_blank   <= '0;
    end else begin
      if (bus.load) begin
        pend_value <= bus.value;
        pend_dp    <= bus.dp_in;
        pend_blank <= bus.blank;
        pend_flag  <= 1'b1;
      end
      if (wrap) begin
        if (bus.load) begin
          sh_value <= bus.value;
          sh_dp    <= bus.dp_in;
          sh_blank <= bus.blank;
        end else if (pend_flag) begin
          sh_value <= pend_value;
          sh_dp    <= pend_dp;
          sh_blank <= pend_blank;
        end
        pend_flag <= 1'b0;
      end
    end
  end

`ifdef SEVEN_SEG_LZ_BLANK_EN
  logic lz_run;
  always_comb begin
    dark   = sh_blank;
    lz_run = 1'b1;
    for (int i = DIGITS - 1; i >= 1; i--) begin
      if (lz_run && (sh_value[4*i +: 4] == 4'h0)) dark[i] = 1'b1;
      else lz_run = 1'b0;
    end
  end
`else
  always_comb begin
    dark = sh_blank;
  end
`endif

  // Suppressed digits keep their dp; only explicit blanking hides it.
  always_comb begin
    nib   = sh_value[{idx, 2'b00} +: 4];
    seg_a = '0;
    dp_a  = 1'b0;
    an_a  = '0;
    if (bus.en) begin
      an_a[idx] = 1'b1;
      if (!sh_blank[idx]) dp_a  = sh_dp[idx];
      if (!dark[idx])     seg_a = decode(nib);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      seg_q <= {7{SEG_ACTIVE_LOW}};
      dp_q  <= SEG_ACTIVE_LOW;
      an_q  <= {DIGITS{AN_ACTIVE_LOW}};
      idx_q <= '0;
      fs_q  <= 1'b0;
    end else begin
      seg_q <= seg_a ^ {7{SEG_ACTIVE_LOW}};
      dp_q  <= dp_a ^ SEG_ACTIVE_LOW;
      an_q  <= an_a ^ {DIGITS{AN_ACTIVE_LOW}};
      idx_q <= idx;
      fs_q  <= bus.en && (idx == '0) && (rc == '0);
    end
  end

  assign bus.seg         = seg_q;
  assign bus.dp          = dp_q;
  assign bus.an          = an_q;
  assign bus.digit_idx   = idx_q;
  assign bus.frame_start = fs_q;
endmodule

// File: tb/tb_seven_seg_scan.sv
// Directed self-checking bench for seven_seg_scan (DIGITS=4, REFRESH_DIV=4, active-low pins).
// Expectations adapt when SEVEN_SEG_LZ_BLANK_EN is defined.
module tb_seven_seg_scan;
  localparam logic [6:0] S0 = 7'b0000001;
  localparam logic [6:0] S1 = 7'b1001111;
  localparam logic [6:0] S2 = 7'b0010010;
  localparam logic [6:0] S3 = 7'b0000110;
  localparam logic [6:0] S4 = 7'b1001100;
  localparam logic [6:0] S6 = 7'b0100000;
  localparam logic [6:0] S7 = 7'b0001111;
  localparam logic [6:0] S8 = 7'b0000000;
  localparam logic [6:0] S9 = 7'b0000100;
  localparam logic [6:0] SA = 7'b0001000;
  localparam logic [6:0] SF = 7'b0111000;
  localparam logic [6:0] DK = 7'b1111111;

  localparam logic [27:0] ALL0   = {S0, S0, S0, S0};
  localparam logic [27:0] F12AF  = {S1, S2, SA, SF};
  localparam logic [27:0] F9876  = {S9, S8, S7, S6};
  localparam logic [27:0] F1234B = {S1, S2, DK, S4};
`ifdef SEVEN_SEG_LZ_BLANK_EN
  localparam logic [27:0] F0030  = {DK, DK, S3, S0};
  localparam logic [27:0] F0000  = {DK, DK, DK, S0};
`else
  localparam logic [27:0] F0030  = {S0, S0, S3, S0};
  localparam logic [27:0] F0000  = ALL0;
`endif

  logic clk;
  logic rst;
  int   errors;
  int   checks;

  seven_seg_scan_if #(.DIGITS(4)) bus ();

  seven_seg_scan #(
    .DIGITS(4), .REFRESH_DIV(4), .SEG_ACTIVE_LOW(1'b1), .AN_ACTIVE_LOW(1'b1)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // data packs {value[15:0], dp_in[3:0], blank[3:0]}
  task automatic applyStimulus(input logic ld, input logic [23:0] data);
    bus.load  = ld;
    bus.value = data[23:8];
    bus.dp_in = data[7:4];
    bus.blank = data[3:0];
  endtask

  task automatic checkOutput(input string tag, input logic [3:0] exp_an, input logic [6:0] exp_seg,
                             input logic exp_dp, input logic [1:0] exp_idx, input logic exp_fs);
    checks++;
    assert (bus.an === exp_an) else begin
      errors++;
      $error("[TB] FAIL %s an: got %b expected %b", tag, bus.an, exp_an);
    end
    checks++;
    assert (bus.seg === exp_seg) else begin
      errors++;
      $error("[TB] FAIL %s seg: got %b expected %b", tag, bus.seg, exp_seg);
    end
    checks++;
    assert (bus.dp === exp_dp) else begin
      errors++;
      $error("[TB] FAIL %s dp: got %b expected %b", tag, bus.dp, exp_dp);
    end
    checks++;
    assert (bus.digit_idx === exp_idx) else begin
      errors++;
      $error("[TB] FAIL %s digit_idx: got %0d expected %0d", tag, bus.digit_idx, exp_idx);
    end
    checks++;
    assert (bus.frame_start === exp_fs) else begin
      errors++;
      $error("[TB] FAIL %s frame_start: got %b expected %b", tag, bus.frame_start, exp_fs);
    end
  endtask

  // Runs ncyc cycles from a frame boundary, optionally issuing loads at cycles la and lb.
  task automatic runFrame(input int frame, input logic [27:0] es, input logic [3:0] edp, input int ncyc,
                          input int la, input logic [23:0] da, input int lb, input logic [23:0] db);
    int         d;
    logic [3:0] an_hot;
    for (int c = 0; c < ncyc; c++) begin
      if (c == la)      applyStimulus(1'b1, da);
      else if (c == lb) applyStimulus(1'b1, db);
      else              applyStimulus(1'b0, 24'h0);
      @(negedge clk);
      d      = c / 4;
      an_hot = 4'b0001 << d;
      checkOutput($sformatf("frame%0d c%0d", frame, c), ~an_hot, es[7*d +: 7], edp[d], 2'(d), c == 0);
    end
    applyStimulus(1'b0, 24'h0);
  endtask

  initial begin
    errors = 0;
    checks = 0;
    rst    = 1'b1;
    bus.en = 1'b0;
    applyStimulus(1'b0, 24'h0);
    repeat (2) @(negedge clk);
    checkOutput("reset", 4'b1111, DK, 1'b1, 2'd0, 1'b0);

    rst    = 1'b0;
    bus.en = 1'b1;
    runFrame(1, ALL0, 4'b1111, 16, -1, 24'h0, -1, 24'h0);
    runFrame(2, ALL0, 4'b1111, 16, 2, {16'h12AF, 4'b0100, 4'b0000}, -1, 24'h0);
    runFrame(3, F12AF, 4'b1011, 16, 4, {16'h5555, 4'b0000, 4'b0000}, 15, {16'h9876, 4'b0001, 4'b0000});
    runFrame(4, F9876, 4'b1110, 16, 6, {16'h1234, 4'b0000, 4'b0010}, -1, 24'h0);
    runFrame(5, F1234B, 4'b1111, 16, 9, {16'h0030, 4'b0000, 4'b0000}, -1, 24'h0);
    runFrame(6, F0030, 4'b1111, 16, 9, {16'h0000, 4'b0000, 4'b0000}, -1, 24'h0);
    runFrame(7, F0000, 4'b1111, 16, -1, 24'h0, -1, 24'h0);

    runFrame(8, F0000, 4'b1111, 6, -1, 24'h0, -1, 24'h0);
    bus.en = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      checkOutput($sformatf("hold%0d", i), 4'b1111, DK, 1'b1, 2'd1, 1'b0);
    end
    bus.en = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      checkOutput($sformatf("resume%0d", i), 4'b1101, F0000[13:7], 1'b1, 2'd1, 1'b0);
    end
    applyStimulus(1'b1, {16'hFFFF, 4'b1111, 4'b0000});
    @(negedge clk);
    checkOutput("resume2", 4'b1011, F0000[20:14], 1'b1, 2'd2, 1'b0);

    applyStimulus(1'b0, 24'h0);
    rst = 1'b1;
    @(negedge clk);
    checkOutput("midreset", 4'b1111, DK, 1'b1, 2'd0, 1'b0);
    rst = 1'b0;
    runFrame(9, F0000, 4'b1111, 16, -1, 24'h0, -1, 24'h0);
    runFrame(10, F0000, 4'b1111, 16, -1, 24'h0, -1, 24'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
